gray_display_scanner: RTL and testbench

GRAY_DISPLAY_SCANNER -- requirements
Module: gray_display_scanner

---
 rtl/gray_disp_pkg.sv | 34 +++
 rtl/gray_debounce.sv | 39 +++
 rtl/gray_display_scanner.sv | 124 ++++++++++++
 tb/tb_gray_display_scanner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_disp_pkg.sv
// Shared constants for the Gray-code display scanner: hex glyphs, blank pattern
// and parameter limits.
package gray_disp_pkg;

  localparam int MAX_WIDTH  = 16;
  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segment patterns, bit0=a .. bit6=g, indexed by nibble value.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return HEX_GLYPH[nib];
  endfunction

endpackage

// File: rtl/gray_debounce.sv
// Accepts a synchronized word only after it has held one value for DEB_CYCLES
// further cycles; any change restarts the count.
module gray_debounce
  import gray_disp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             accept
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [WIDTH-1:0] cand_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             same;

  assign same   = (din == cand_p0);
  // Fires exactly once per stable run; the saturated count keeps it quiet afterwards.
  assign accept = same && (cnt_p0 == CNT_W'(DEB_CYCLES - 1));
  assign dout   = cand_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_p0 <= '0;
      cnt_p0  <= '0;
    end else if (!same) begin
      cand_p0 <= din;
      cnt_p0  <= '0;
    end else if (cnt_p0 != CNT_W'(DEB_CYCLES)) begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

endmodule

// File: rtl/gray_display_scanner.sv
// Gray-coded switch input -> binary LEDs plus multiplexed hex 7-segment scan.
// Optional input debounce is enabled by defining GRAY_DEBOUNCE_EN.
module gray_display_scanner
  import gray_disp_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEB_CYCLES  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      gray_in,
  output logic [WIDTH-1:0]      led,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  bin_valid
);

  localparam int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int USED_DIGITS = (WIDTH + 3) / 4;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("gray_display_scanner: WIDTH out of range");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("gray_display_scanner: NUM_DIGITS out of range");
  end
  if (REFRESH_DIV < 1 || DEB_CYCLES < 1) begin : g_bad_div
    $error("gray_display_scanner: REFRESH_DIV and DEB_CYCLES must be >= 1");
  end

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous switch input.
  logic [WIDTH-1:0] sync_p0, sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= gray_in;
      sync_p1 <= sync_p0;
    end
  end

  logic             load;
  logic [WIDTH-1:0] load_val;

`ifdef GRAY_DEBOUNCE_EN
  gray_debounce #(
    .WIDTH      (WIDTH),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .din    (sync_p1),
    .dout   (load_val),
    .accept (load)
  );
`else
  assign load     = 1'b1;
  assign load_val = sync_p1;
`endif

  // Stage p2: converted value register and change strobe.
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] bin_q;
  logic             vld_p2;

  assign bin_next = gray_to_bin(load_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= load && (bin_next != bin_q);
      if (load) bin_q <= bin_next;
    end
  end

  assign led       = bin_q;
  assign bin_valid = vld_p2;

  // Refresh divider and digit index.
  logic [CNT_W-1:0] refresh_cnt;
  logic [IDX_W-1:0] digit_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Both an and seg decode from the same registered index, so they never disagree.
  logic [4*MAX_DIGITS-1:0] nib_vec;
  logic [3:0]              nibble;

  always_comb begin
    nib_vec              = '0;
    nib_vec[WIDTH-1:0]   = bin_q;
    nibble               = nib_vec[4*int'(digit_idx) +: 4];
    if (int'(digit_idx) >= USED_DIGITS) seg = SEG_BLANK;
    else                                seg = hex_glyph(nibble);
    an = ~(NUM_DIGITS'(1) << digit_idx);
  end

endmodule

// File: tb/tb_gray_display_scanner.sv
// Randomized self-checking bench for gray_display_scanner against a
// history-based reference model.
module tb_gray_display_scanner;

  localparam int WIDTH = 8;
  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int DEB   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gray_in = 8'h00;
  logic [7:0] led;
  logic [6:0] seg;
  logic [3:0] an;
  logic       bin_valid;

  int checks   = 0;
  int failures = 0;

  int         hist[$];
  int         n_edges = 0;
  logic [7:0] led_m   = 8'h00;
  logic       valid_m = 1'b0;

  gray_display_scanner #(
    .WIDTH       (WIDTH),
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .led       (led),
    .seg       (seg),
    .an        (an),
    .bin_valid (bin_valid)
  );

  always #5 clk = ~clk;

  // Binary value is the XOR of all right shifts of the Gray word.
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b = 8'h00;
    for (int s = 0; s < 8; s++) b ^= (g >> s);
    return b;
  endfunction

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic int exp_idx();
    return (n_edges / RD) % ND;
  endfunction

  function automatic logic [3:0] exp_an();
    return 4'hF & ~(4'b0001 << exp_idx());
  endfunction

  function automatic logic [6:0] exp_seg();
    int k = exp_idx();
    if (k >= (WIDTH + 3) / 4) return 7'h7F;
    return glyph((int'(led_m) >> (4 * k)) & 15);
  endfunction

  // One clock edge of stimulus followed by the model update; outputs are then stable.
  task automatic step(input logic [7:0] g, input logic r);
    logic [7:0] nv;
    bit         stable;
    gray_in = g;
    rst     = r;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      repeat (DEB + 2) hist.push_back(0);
      n_edges = 0;
      led_m   = 8'h00;
      valid_m = 1'b0;
    end else begin
      hist.push_back(int'(g));
      n_edges++;
`ifdef GRAY_DEBOUNCE_EN
      stable = 1'b1;
      for (int j = 0; j <= DEB; j++)
        if (hist[hist.size()-3-j] != hist[hist.size()-3]) stable = 1'b0;
      nv = stable ? g2b(8'(hist[hist.size()-3])) : led_m;
`else
      stable = 1'b1;
      nv = g2b(8'(hist[hist.size()-3]));
`endif
      valid_m = stable && (nv != led_m);
      led_m   = nv;
      while (hist.size() > 16) void'(hist.pop_front());
    end
  endtask

  task automatic test_reset();
    step(8'h5A, 1'b1);
    step(8'h5A, 1'b1);
    checks++;
    if (led !== 8'h00) begin failures++; $display("FAIL reset_led got=%h want=00", led); end
    checks++;
    if (an !== 4'b1110) begin failures++; $display("FAIL reset_an got=%b want=1110", an); end
    checks++;
    if (seg !== 7'b1000000) begin failures++; $display("FAIL reset_seg got=%b want=1000000", seg); end
    checks++;
    if (bin_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bin_valid); end
  endtask

  task automatic test_convert();
    int pulses = 0;
    for (int e = 1; e <= 6; e++) begin
      step(8'h03, 1'b0);
      pulses += int'(bin_valid);
      checks++;
      if (led !== ((e >= 3) ? 8'h02 : 8'h00)) begin
        failures++; $display("FAIL conv_latency edge=%0d got=%h want=%h", e, led, (e >= 3) ? 8'h02 : 8'h00);
      end
      checks++;
      if (bin_valid !== (e == 3)) begin
        failures++; $display("FAIL conv_strobe edge=%0d got=%b want=%b", e, bin_valid, e == 3);
      end
      if (e == 3) begin
        checks++;
        if (seg !== 7'b0100100) begin failures++; $display("FAIL conv_seg got=%b want=0100100", seg); end
      end
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL conv_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_scan();
    for (int e = 0; e < 20; e++) begin
      step(8'h80, 1'b0);
      checks++;
      if ({led, an, seg} !== {led_m, exp_an(), exp_seg()}) begin
        failures++;
        $display("FAIL scan cyc=%0d got led=%h an=%b seg=%b want led=%h an=%b seg=%b",
                 e, led, an, seg, led_m, exp_an(), exp_seg());
      end
      if (led_m == 8'hFF) begin
        checks++;
        if (seg !== ((an == 4'b1110 || an == 4'b1101) ? 7'b0001110 : 7'b1111111)) begin
          failures++; $display("FAIL scan_glyph an=%b got seg=%b", an, seg);
        end
      end
    end
  endtask

  task automatic test_reset_midscan();
    int guard = 0;
    while (!(exp_idx() == 2 && led_m == 8'hFF) && guard < 40) begin
      step(8'h80, 1'b0);
      guard++;
    end
    checks++;
    if (an !== 4'b1011 || led !== 8'hFF) begin
      failures++; $display("FAIL midscan_setup got an=%b led=%h want an=1011 led=ff", an, led);
    end
    step(8'h80, 1'b1);
    checks++;
    if ({an, led, bin_valid} !== {4'b1110, 8'h00, 1'b0}) begin
      failures++; $display("FAIL midscan_reset got an=%b led=%h v=%b want an=1110 led=00 v=0", an, led, bin_valid);
    end
    for (int e = 1; e <= RD; e++) begin
      step(8'h80, 1'b0);
      checks++;
      if (an !== ((e < RD) ? 4'b1110 : 4'b1101)) begin
        failures++; $display("FAIL midscan_restart edge=%0d got an=%b want=%b", e, an, (e < RD) ? 4'b1110 : 4'b1101);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, pulses_m = 0;
    for (int e = 0; e < 24; e++) begin
      step(8'($urandom), 1'b0);
      pulses   += int'(bin_valid);
      pulses_m += int'(valid_m);
      checks++;
      if (led !== led_m || bin_valid !== valid_m) begin
        failures++; $display("FAIL b2b cyc=%0d got led=%h v=%b want led=%h v=%b", e, led, bin_valid, led_m, valid_m);
      end
    end
    checks++;
    if (pulses != pulses_m) begin failures++; $display("FAIL b2b_pulses got=%0d want=%0d", pulses, pulses_m); end
  endtask

  task automatic test_random();
    logic [7:0] g;
    int         hold;
    for (int burst = 0; burst < 120; burst++) begin
      g    = 8'($urandom);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        step(g, ($urandom_range(0, 59) == 0));
        checks++;
        if (led !== led_m) begin failures++; $display("FAIL rand_led got=%h want=%h", led, led_m); end
        checks++;
        if (bin_valid !== valid_m) begin failures++; $display("FAIL rand_valid got=%b want=%b", bin_valid, valid_m); end
        checks++;
        if (an !== exp_an()) begin failures++; $display("FAIL rand_an got=%b want=%b", an, exp_an()); end
        checks++;
        if (seg !== exp_seg()) begin failures++; $display("FAIL rand_seg got=%b want=%b", seg, exp_seg()); end
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef GRAY_DEBOUNCE_EN
    test_convert();
`endif
    test_scan();
    test_reset_midscan();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
